mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL be the number of cycles a memory access occupies; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 4, SHALL be the number of consecutive data grants allowed while a fetch waits; legal range 1..15.
REQ-003 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 if_req_i  input  1  SHALL be the instruction-fetch request, held until if_ack_o.
REQ-006 if_addr_i  input  32  SHALL be the fetch address.
REQ-007 if_ack_o  output  1  SHALL be a one-cycle fetch completion pulse.
REQ-008 if_data_o  output  32  SHALL be the fetched word, valid while if_ack_o is high.
REQ-009 dm_req_i  input  1  SHALL be the data-memory request, held until dm_ack_o.
REQ-010 dm_we_i  input  1  SHALL select write (1) or read (0) for the data request.
REQ-011 dm_addr_i / dm_wdata_i  input  32 / 32  SHALL be the data address and write data.
REQ-012 dm_ack_o  output  1  SHALL be a one-cycle data completion pulse.
REQ-013 dm_rdata_o  output  32  SHALL be the read word, valid while dm_ack_o is high.
REQ-014 mem_en_o / mem_we_o  output  1 / 1  SHALL be the shared memory enable and write strobe.
REQ-015 mem_addr_o / mem_wdata_o  output  32 / 32  SHALL be the shared memory address and write data.
REQ-016 mem_rdata_i  input  32  SHALL be the memory read data, valid in the last access cycle.
REQ-017 stall_o  output  1  SHALL be high while any request is pending and not yet acknowledged.

Function
REQ-018 The FSM SHALL have the states IDLE, IF_ACC, DM_ACC and RESP.
REQ-019 IDLE: dm_req_i -> DM_ACC; else if_req_i -> IF_ACC; else stay in IDLE; the chosen request's address, write enable and write data SHALL be latched on the transition edge.
REQ-020 IF_ACC/DM_ACC SHALL last exactly MEM_LAT cycles, timed by a down-counter loaded with MEM_LAT-1; the last cycle goes to RESP.
REQ-021 mem_en_o SHALL be high and mem_addr_o SHALL equal the latched address during every access cycle; otherwise mem_en_o = 0 and mem_addr_o = 0.
REQ-022 mem_we_o SHALL be high only in the first DM_ACC cycle of a write; mem_wdata_o SHALL equal the latched wdata during DM_ACC.
REQ-023 mem_rdata_i SHALL be registered on the last access cycle; RESP SHALL pulse the ack of the granted port with that data for one cycle.
REQ-024 A write SHALL also ack in RESP, with dm_rdata_o = 0.
REQ-025 if_data_o and dm_rdata_o SHALL be 0 when their ack is low.
REQ-026 RESP SHALL grant nothing and always return to IDLE; latency from request in IDLE to ack SHALL be MEM_LAT+1 cycles, throughput one access per MEM_LAT+2 cycles.
REQ-027 Request inputs SHALL be ignored outside IDLE; a request dropped before its ack is undefined for the requester but SHALL NOT hang the FSM.
REQ-028 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally.

Reset
REQ-029 When rst_i is low, the block SHALL asynchronously go to IDLE and clear all counters, latches and outputs to 0.
REQ-030 A reset during an access SHALL abort it: no ack is issued and mem_en_o/mem_we_o drop immediately.

Configuration
REQ-031 With ARB_STARVE_EN defined, a 4-bit counter SHALL count DM grants made in IDLE while if_req_i is high.
REQ-032 With ARB_STARVE_EN defined, once the counter reaches STARVE_MAX the next IDLE arbitration SHALL grant IF even if dm_req_i is high.
REQ-033 With ARB_STARVE_EN defined, the counter SHALL clear on any IF grant and whenever if_req_i is low in IDLE.
REQ-034 Without ARB_STARVE_EN, the FSM SHALL use strict data-over-fetch priority and SHALL contain no starvation counter.

Verification
REQ-035 MEM_LAT=2, single if_req_i at addr 0x10, memory returns 0xDEADBEEF -> mem_en_o high for 2 cycles, if_ack_o with if_data_o=0xDEADBEEF 3 cycles after the request.
REQ-036 if_req_i and dm_req_i (read 0x40) raised in the same cycle -> DM served first, dm_ack_o at +3; IF granted in the following IDLE, if_ack_o at +7.
REQ-037 dm write 0x1234_5678 to 0x80 -> mem_we_o high exactly 1 cycle, mem_addr_o=0x80, dm_ack_o with dm_rdata_o=0.
REQ-038 ARB_STARVE_EN, STARVE_MAX=4, dm_req_i held high continuously with if_req_i pending -> 4 DM grants, then 1 IF grant, then the counter restarts.
REQ-039 rst_i pulsed low in the second DM_ACC cycle -> mem_en_o=0 at once, no dm_ack_o, FSM in IDLE; a request re-issued after reset completes normally.
REQ-040 No requests, 20 cycles -> mem_en_o, stall_o and both acks stay 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; data wins
// unless ARB_STARVE_EN is defined, which bounds how long a waiting fetch can be starved.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
  end

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, dm_sel;
  logic        grant_dm, grant_if;
  logic        last_cyc;

`ifdef ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic       starve_hit;

  assign starve_hit = (starve_cnt >= 4'(STARVE_MAX));
  // A starved fetch overrides the data port's normal priority for one grant.
  assign grant_dm   = dm_req_i & ~(if_req_i & starve_hit);
`else
  assign grant_dm   = dm_req_i;
`endif
  assign grant_if = if_req_i & ~grant_dm;

  assign last_cyc = ((state == IF_ACC) || (state == DM_ACC)) && (cnt == 4'd0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    if_ack_o    = 1'b0;
    if_data_o   = 32'd0;
    dm_ack_o    = 1'b0;
    dm_rdata_o  = 32'd0;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nxt = DM_ACC;
          cnt_nxt   = LAT_LOAD;
        end else if (grant_if) begin
          state_nxt = IF_ACC;
          cnt_nxt   = LAT_LOAD;
        end
      end
      IF_ACC: begin
        mem_en_o   = 1'b1;
        mem_addr_o = addr_q;
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DM_ACC: begin
        mem_en_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = we_q && (cnt == LAT_LOAD);
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        state_nxt = IDLE;
        if (dm_sel) begin
          dm_ack_o   = 1'b1;
          dm_rdata_o = we_q ? 32'd0 : rdata_q;
        end else begin
          if_ack_o  = 1'b1;
          if_data_o = rdata_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      dm_sel  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE) begin
        if (grant_dm) begin
          addr_q  <= dm_addr_i;
          wdata_q <= dm_wdata_i;
          we_q    <= dm_we_i;
          dm_sel  <= 1'b1;
        end else if (grant_if) begin
          addr_q  <= if_addr_i;
          wdata_q <= 32'd0;
          we_q    <= 1'b0;
          dm_sel  <= 1'b0;
        end
      end
      if (last_cyc) rdata_q <= mem_rdata_i;
    end
  end

`ifdef ARB_STARVE_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!if_req_i || grant_if)
        starve_cnt <= 4'd0;
      else if (grant_dm && starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table, reset/starvation sequences and a randomized run against a
// transaction-timeline reference model of mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic        mem_en, mem_we, stall;
  logic [31:0] if_addr, if_data, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory behind the port: data is only valid in the last cycle of an access.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int acc_run;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) acc_run <= 0;
    else      acc_run <= mem_en ? acc_run + 1 : 0;
  end
  always @(posedge clk) begin
    if (rst && mem_we) env_mem[mem_addr] = mem_wdata;
  end
  always @(mem_en or mem_addr or acc_run) begin
    mem_rdata = (mem_en && acc_run == L - 1) ? env_read(mem_addr) : (32'hBAD0_0000 | 32'(acc_run));
  end

  typedef struct {
    logic        ifr, dmr, we;
    logic [31:0] ia, da, wd;
    int          exp_if_cyc, exp_dm_cyc;
    logic [31:0] exp_if_dat, exp_dm_dat;
    int          exp_en, exp_we;
  } vec_t;
  vec_t vt[5];

  task automatic set_vec(input int i, input logic ifr, input logic dmr, input logic we,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input int ic, input logic [31:0] idat, input int dc, input logic [31:0] ddat,
                         input int en, input int wen);
    vt[i].ifr = ifr; vt[i].dmr = dmr; vt[i].we = we;
    vt[i].ia = ia; vt[i].da = da; vt[i].wd = wd;
    vt[i].exp_if_cyc = ic; vt[i].exp_if_dat = idat;
    vt[i].exp_dm_cyc = dc; vt[i].exp_dm_dat = ddat;
    vt[i].exp_en = en; vt[i].exp_we = wen;
  endtask

  // Raise the vector's requests at a falling edge, hold each until acked, measure offsets.
  task automatic run_vec(input vec_t v, input string tag);
    int if_cyc, dm_cyc, if_n, dm_n, en_n, we_n, leak;
    logic [31:0] if_dat, dm_dat;
    if_cyc = 0; dm_cyc = 0; if_n = 0; dm_n = 0; en_n = 0; we_n = 0; leak = 0;
    if_dat = 32'd0; dm_dat = 32'd0;
    if_req = v.ifr; if_addr = v.ia;
    dm_req = v.dmr; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, ".stall"}, 64'(stall), 64'(v.ifr | v.dmr));
      if (mem_en) en_n++;
      if (mem_we) begin
        we_n++;
        check({tag, ".we_addr"}, 64'(mem_addr), 64'(v.da));
        check({tag, ".we_data"}, 64'(mem_wdata), 64'(v.wd));
      end
      if (!if_ack && if_data != 32'd0) leak++;
      if (!dm_ack && dm_rdata != 32'd0) leak++;
      if (if_ack) begin
        if_n++;
        if (if_cyc == 0) begin if_cyc = c; if_dat = if_data; end
        if_req = 1'b0;
      end
      if (dm_ack) begin
        dm_n++;
        if (dm_cyc == 0) begin dm_cyc = c; dm_dat = dm_rdata; end
        dm_req = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    check({tag, ".if_cyc"}, 64'(if_cyc), 64'(v.exp_if_cyc));
    check({tag, ".dm_cyc"}, 64'(dm_cyc), 64'(v.exp_dm_cyc));
    check({tag, ".if_acks"}, 64'(if_n), 64'(v.exp_if_cyc != 0));
    check({tag, ".dm_acks"}, 64'(dm_n), 64'(v.exp_dm_cyc != 0));
    if (v.exp_if_cyc != 0) check({tag, ".if_data"}, 64'(if_dat), 64'(v.exp_if_dat));
    if (v.exp_dm_cyc != 0) check({tag, ".dm_rdata"}, 64'(dm_dat), 64'(v.exp_dm_dat));
    check({tag, ".en_cycles"}, 64'(en_n), 64'(v.exp_en));
    check({tag, ".we_cycles"}, 64'(we_n), 64'(v.exp_we));
    check({tag, ".data_idle_zero"}, 64'(leak), 64'd0);
  endtask

  // Reference model state for the randomized run.
  int          cyc, next_idle, g_start, m_starve;
  logic        g_valid, g_dm, g_we;
  logic [31:0] g_addr, g_wdata, g_rdata;

  initial begin
    int leak, n;
    int grants[10];
    vec_t rv;
    logic e_en, e_we, e_ifa, e_dma, e_stall, force_if, old_if, old_dm;
    logic [31:0] e_addr, e_ifd, e_dmd;

    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    env_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    check("reset.ctrl", 64'({if_ack, dm_ack, mem_en, mem_we, stall}), 64'd0);
    check("reset.data", 64'(if_data | dm_rdata | mem_addr | mem_wdata), 64'd0);
    rst = 1'b1;

    leak = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_en | stall | if_ack | dm_ack) leak++;
    end
    check("idle20.quiet_cycles", 64'(leak), 64'd0);

    //        i ifr  dmr  we   ia          da          wd            ic idat              dc ddat          en we
    set_vec(0, 1'b1, 1'b0, 1'b0, 32'h10,     32'h0,      32'h0,        3, 32'hDEAD_BEEF,    0, 32'h0,         2, 0);
    set_vec(1, 1'b1, 1'b1, 1'b0, 32'h14,     32'h40,     32'h0,        7, dflt(32'h14),     3, dflt(32'h40),  4, 0);
    set_vec(2, 1'b0, 1'b1, 1'b1, 32'h0,      32'h80,     32'h1234_5678, 0, 32'h0,           3, 32'h0,         2, 1);
    set_vec(3, 1'b0, 1'b1, 1'b0, 32'h0,      32'h80,     32'h0,        0, 32'h0,            3, 32'h1234_5678, 2, 0);
    set_vec(4, 1'b1, 1'b1, 1'b1, 32'h18,     32'h84,     32'hCAFE_F00D, 7, dflt(32'h18),    3, 32'h0,         4, 1);
    ref_mem[32'h80] = 32'h1234_5678;
    ref_mem[32'h84] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset in the second access cycle aborts the transfer.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
    @(posedge clk); @(posedge clk); #1;
    check("abort.pre_en", 64'(mem_en), 64'd1);
    rst = 1'b0;
    #1;
    check("abort.en_drop", 64'({mem_en, mem_we}), 64'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    leak = 0;
    repeat (6) begin
      @(negedge clk);
      if (dm_ack | if_ack | mem_en) leak++;
    end
    check("abort.no_ack", 64'(leak), 64'd0);
    rv = vt[3];
    rv.da = 32'h90; rv.exp_dm_dat = dflt(32'h90);
    run_vec(rv, "reissue");

    // Data held high continuously with a fetch pending.
    n = 0;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (dm_ack && n < 10) begin grants[n] = 0; n++; end
      if (if_ack && n < 10) begin grants[n] = 1; n++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("starve.grant_count", 64'(n), 64'd10);
    for (int i = 0; i < n; i++) begin
`ifdef ARB_STARVE_EN
      check($sformatf("starve.grant%0d_is_if", i), 64'(grants[i]), 64'((i % (SMAX + 1)) == SMAX));
`else
      check($sformatf("strict.grant%0d_is_if", i), 64'(grants[i]), 64'd0);
`endif
    end
    repeat (4) @(negedge clk);

    // Randomized traffic against a timeline model: a grant at an idle cycle k
    // occupies k+1..k+L on the bus, acks at k+L+1 and frees the arbiter at k+L+2.
    cyc = 0; next_idle = 0; g_valid = 1'b0; m_starve = 0; g_start = 0;
    g_dm = 1'b0; g_we = 1'b0; g_addr = 32'd0; g_wdata = 32'd0; g_rdata = 32'd0;
    for (int k = 0; k < 400; k++) begin
      e_en    = g_valid && cyc > g_start && cyc <= g_start + L;
      e_addr  = e_en ? g_addr : 32'd0;
      e_we    = e_en && g_dm && g_we && cyc == g_start + 1;
      e_ifa   = g_valid && cyc == g_start + L + 1 && !g_dm;
      e_dma   = g_valid && cyc == g_start + L + 1 && g_dm;
      e_ifd   = e_ifa ? g_rdata : 32'd0;
      e_dmd   = (e_dma && !g_we) ? g_rdata : 32'd0;
      e_stall = (if_req && !e_ifa) || (dm_req && !e_dma);
      check($sformatf("rnd.ctrl@%0d{ifa,dma,en,we,stall}", cyc),
            64'({if_ack, dm_ack, mem_en, mem_we, stall}), 64'({e_ifa, e_dma, e_en, e_we, e_stall}));
      check($sformatf("rnd.addr@%0d", cyc), 64'(mem_addr), 64'(e_addr));
      check($sformatf("rnd.if_data@%0d", cyc), 64'(if_data), 64'(e_ifd));
      check($sformatf("rnd.dm_rdata@%0d", cyc), 64'(dm_rdata), 64'(e_dmd));
      if (e_en && g_dm) check($sformatf("rnd.wdata@%0d", cyc), 64'(mem_wdata), 64'(g_wdata));

      old_if = if_req; old_dm = dm_req;
      if (if_ack) if_req = 1'b0;
      else if (!old_if && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = 32'h2000 + {$urandom_range(0, 15), 2'b00};
      end
      if (dm_ack) dm_req = 1'b0;
      else if (!old_dm && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_we = $urandom_range(0, 1) == 1;
        dm_addr = 32'h1000 + {$urandom_range(0, 7), 2'b00}; dm_wdata = $urandom;
      end

      if (cyc >= next_idle) begin
`ifdef ARB_STARVE_EN
        force_if = if_req && m_starve >= SMAX;
`else
        force_if = 1'b0;
`endif
        if ((dm_req && !force_if) || if_req) begin
          g_valid = 1'b1; g_start = cyc; next_idle = cyc + L + 2;
          g_dm = dm_req && !force_if;
          g_addr = g_dm ? dm_addr : if_addr;
          g_we = g_dm && dm_we;
          g_wdata = dm_wdata;
          g_rdata = g_we ? 32'd0 : ref_read(g_addr);
          if (g_we) ref_mem[g_addr] = dm_wdata;
        end
        if (!if_req || (g_valid && g_start == cyc && !g_dm)) m_starve = 0;
        else if (g_valid && g_start == cyc && g_dm) m_starve++;
      end
      cyc++;
      @(negedge clk);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (L + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
